// File: rtl/pitch_pkg.sv
// Shared constants and encodings for the ping-pong sample buffer read side.
package pitch_pkg;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 12;
  localparam int BUF_DEPTH = 2048;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  typedef enum logic {
    TAG_AN  = 1'b0,
    TAG_DBG = 1'b1
  } tag_e;

endpackage

// File: rtl/buf_read_pipe.sv
// Carries valid/requester/bank alongside the BRAM read latency, then captures
// the selected bank's data into the requester's output register.
module buf_read_pipe #(
  parameter int DATA_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_vld_i,
  input  logic              issue_tag_i,
  input  logic              issue_bank_i,
  input  logic [DATA_W-1:0] dout0_i,
  input  logic [DATA_W-1:0] dout1_i,
  output logic [DATA_W-1:0] an_rdata_o,
  output logic              an_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_rvalid_o
);
  import pitch_pkg::*;

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] tag_q;
  logic [RD_LAT-1:0] bank_q;
  logic [DATA_W-1:0] dout_sel;
  logic              hit_an;
  logic              hit_dbg;
  logic [DATA_W-1:0] an_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              an_rvalid_q;
  logic              dbg_rvalid_q;

  // The bank tag travels with the request so a swap mid-flight cannot redirect data.
  assign dout_sel = bank_q[RD_LAT-1] ? dout1_i : dout0_i;
  assign hit_an   = vld_q[RD_LAT-1] & (tag_q[RD_LAT-1] == TAG_AN);
  assign hit_dbg  = vld_q[RD_LAT-1] & (tag_q[RD_LAT-1] == TAG_DBG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      tag_q  <= '0;
      bank_q <= '0;
    end else begin
      vld_q[0]  <= issue_vld_i;
      tag_q[0]  <= issue_tag_i;
      bank_q[0] <= issue_bank_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        tag_q[i]  <= tag_q[i-1];
        bank_q[i] <= bank_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_rdata_q   <= '0;
      dbg_rdata_q  <= '0;
      an_rvalid_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      an_rvalid_q  <= hit_an;
      dbg_rvalid_q <= hit_dbg;
      if (hit_an) begin
        an_rdata_q <= dout_sel;
      end
      if (hit_dbg) begin
        dbg_rdata_q <= dout_sel;
      end
    end
  end

  assign an_rdata_o   = an_rdata_q;
  assign an_rvalid_o  = an_rvalid_q;
  assign dbg_rdata_o  = dbg_rdata_q;
  assign dbg_rvalid_o = dbg_rvalid_q;

endmodule

// File: rtl/pingpong_read_scheduler.sv
// Read-side controller for the ping-pong sample buffer: round FSM with timeout,
// analyzer/debug read-port arbitration and the registered BRAM read issue stage.
module pingpong_read_scheduler #(
  parameter int ADDR_W       = pitch_pkg::ADDR_W,
  parameter int DATA_W       = pitch_pkg::DATA_W,
  parameter int RD_LAT       = 1,
  parameter int TIMEOUT      = 1048576,
  parameter int DBG_MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_round,
  input  logic              now_writing,
  output logic              an_start,
  input  logic              an_done,
  input  logic              an_req,
  input  logic [ADDR_W-1:0] an_addr,
  output logic              an_gnt,
  output logic [DATA_W-1:0] an_rdata,
  output logic              an_rvalid,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [1:0]        buf_en,
  input  logic [DATA_W-1:0] buf_dout0,
  input  logic [DATA_W-1:0] buf_dout1,
  output logic              read_bank,
  output logic              f0_done,
  output logic              timeout_err
);
  import pitch_pkg::*;

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WT_W = $clog2(DBG_MAX_WAIT + 1);

  state_e            state_q;
  logic              an_start_q;
  logic              f0_done_q;
  logic              read_bank_q;
  logic              timeout_err_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              to_hit;
  logic [WT_W-1:0]   wait_q;
  logic [WT_W-1:0]   wait_d;
  logic              an_elig;
  logic              dbg_force;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [1:0]        buf_en_q;
  logic              iss_tag_q;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

  // A new round always restarts the analyzer, even if the previous one is unfinished.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      an_start_q    <= 1'b0;
      f0_done_q     <= 1'b1;
      read_bank_q   <= 1'b1;
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      an_start_q <= 1'b0;
      if (start_round) begin
        state_q       <= ST_START;
        an_start_q    <= 1'b1;
        read_bank_q   <= now_writing;
        f0_done_q     <= 1'b0;
        timeout_err_q <= 1'b0;
        to_cnt_q      <= '0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_START: state_q <= ST_BUSY;
          ST_BUSY: begin
            if (an_done) begin
              state_q   <= ST_IDLE;
              f0_done_q <= 1'b1;
            end else if (to_hit) begin
              state_q       <= ST_IDLE;
              f0_done_q     <= 1'b1;
              timeout_err_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Analyzer has priority until the dumper has waited long enough to force one grant.
  assign an_elig   = (state_q == ST_BUSY) & an_req;
  assign dbg_force = dbg_req & (wait_q == WT_W'(DBG_MAX_WAIT - 1));
  assign dbg_gnt   = dbg_req & (~an_elig | dbg_force);
  assign an_gnt    = an_elig & ~dbg_force;

  always_comb begin
    wait_d = wait_q;
    if (dbg_gnt) begin
      wait_d = '0;
    end else if (dbg_req) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q     <= '0;
      buf_addr_q <= '0;
      buf_en_q   <= 2'b00;
      iss_tag_q  <= TAG_AN;
    end else begin
      wait_q <= wait_d;
      if (an_gnt | dbg_gnt) begin
        buf_addr_q <= dbg_gnt ? dbg_addr : an_addr;
        buf_en_q   <= read_bank_q ? 2'b10 : 2'b01;
        iss_tag_q  <= dbg_gnt ? TAG_DBG : TAG_AN;
      end else begin
        buf_en_q <= 2'b00;
      end
    end
  end

  buf_read_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk          (clk),
    .rst_n        (rst),
    .issue_vld_i  (|buf_en_q),
    .issue_tag_i  (iss_tag_q),
    .issue_bank_i (buf_en_q[1]),
    .dout0_i      (buf_dout0),
    .dout1_i      (buf_dout1),
    .an_rdata_o   (an_rdata),
    .an_rvalid_o  (an_rvalid),
    .dbg_rdata_o  (dbg_rdata),
    .dbg_rvalid_o (dbg_rvalid)
  );

  assign an_start    = an_start_q;
  assign f0_done     = f0_done_q;
  assign read_bank   = read_bank_q;
  assign timeout_err = timeout_err_q;
  assign buf_addr    = buf_addr_q;
  assign buf_en      = buf_en_q;

endmodule

// File: tb/tb_pingpong_read_scheduler.sv
// Randomized scoreboard bench for pingpong_read_scheduler with a round/arbiter reference model.
`timescale 1ns/1ps
module tb_pingpong_read_scheduler;
  localparam int AW = 11;
  localparam int DW = 12;
  localparam int RD_LAT = 1;
  localparam int TIMEOUT = 100;
  localparam int DBG_MAX_WAIT = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_round = 0, now_writing = 0, an_done = 0, an_req = 0, dbg_req = 0;
  logic [AW-1:0] an_addr = '0, dbg_addr = '0;
  logic an_start, an_gnt, an_rvalid, dbg_gnt, dbg_rvalid, read_bank, f0_done, timeout_err;
  logic [DW-1:0] an_rdata, dbg_rdata;
  logic [AW-1:0] buf_addr;
  logic [1:0] buf_en;
  logic [DW-1:0] buf_dout0 = '0, buf_dout1 = '0;

  always #5 clk = ~clk;

  pingpong_read_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT), .DBG_MAX_WAIT(DBG_MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .start_round(start_round), .now_writing(now_writing),
    .an_start(an_start), .an_done(an_done), .an_req(an_req), .an_addr(an_addr),
    .an_gnt(an_gnt), .an_rdata(an_rdata), .an_rvalid(an_rvalid),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .dbg_rvalid(dbg_rvalid), .buf_addr(buf_addr), .buf_en(buf_en),
    .buf_dout0(buf_dout0), .buf_dout1(buf_dout1), .read_bank(read_bank),
    .f0_done(f0_done), .timeout_err(timeout_err)
  );

  // Two single-port BRAM banks with one cycle of read latency.
  logic [DW-1:0] mem [0:1][0:2047];
  always @(posedge clk) begin
    if (buf_en[0]) buf_dout0 <= mem[0][buf_addr];
    if (buf_en[1]) buf_dout1 <= mem[1][buf_addr];
  end

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t an_q[$];
  exp_t dbg_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: round progress, owned bank, dbg starvation count, issued read.
  bit m_active, m_startp, m_terr, m_bank;
  int m_busy, m_wait;
  logic [1:0] m_en;
  logic [AW-1:0] m_addr;
  bit last_dbg_gnt;

  task automatic model_reset();
    m_active = 0; m_startp = 0; m_terr = 0; m_bank = 1;
    m_busy = 0; m_wait = 0; m_en = 2'b00; m_addr = '0;
    an_q.delete(); dbg_q.delete();
  endtask

  task automatic step(input bit sr, input bit nw, input bit dn, input bit ar,
                      input logic [AW-1:0] aa, input bit dr, input logic [AW-1:0] da);
    bit busy, elig, frc, ga, gd;
    @(negedge clk);
    start_round = sr; now_writing = nw; an_done = dn;
    an_req = ar; an_addr = aa; dbg_req = dr; dbg_addr = da;
    #1;
    busy = m_active && !m_startp;
    elig = busy && ar;
    frc  = dr && (m_wait == DBG_MAX_WAIT - 1);
    gd   = dr && (!elig || frc);
    ga   = elig && !frc;
    last_dbg_gnt = dbg_gnt;
    chk("an_gnt", an_gnt, ga);
    chk("dbg_gnt", dbg_gnt, gd);
    chk("f0_done", f0_done, !m_active);
    chk("read_bank", read_bank, m_bank);
    chk("an_start", an_start, m_startp);
    chk("timeout_err", timeout_err, m_terr);
    chk("buf_en", buf_en, m_en);
    if (m_en != 2'b00) chk("buf_addr", buf_addr, m_addr);
    if (ga) an_q.push_back('{mem[m_bank][aa], cyc + 2 + RD_LAT});
    if (gd) dbg_q.push_back('{mem[m_bank][da], cyc + 2 + RD_LAT});
    m_en = (ga || gd) ? (m_bank ? 2'b10 : 2'b01) : 2'b00;
    if (ga || gd) m_addr = gd ? da : aa;
    if (gd) m_wait = 0;
    else if (dr) m_wait++;
    if (sr) begin
      m_bank = nw; m_active = 1; m_startp = 1; m_terr = 0; m_busy = 0;
    end else if (m_startp) begin
      m_startp = 0;
    end else if (busy) begin
      if (dn) m_active = 0;
      else if (m_busy == TIMEOUT - 1) begin m_active = 0; m_terr = 1; end
      else m_busy++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, '0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_f0_done", f0_done, 1);
    chk("rst_read_bank", read_bank, 1);
    chk("rst_an_start", an_start, 0);
    chk("rst_buf_en", buf_en, 0);
    chk("rst_buf_addr", buf_addr, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_rvalid", {an_rvalid, dbg_rvalid}, 0);
    chk("rst_rdata", {an_rdata, dbg_rdata}, 0);
  endtask

  // Monitor: pops an expectation whenever a read completes, or when one is overdue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (an_rvalid) begin
          if (an_q.size() == 0) chk("an_rvalid_unexpected", 1, 0);
          else begin
            e = an_q.pop_front();
            chk("an_rdata", an_rdata, e.data);
            chk("an_latency", cyc, e.due);
          end
        end else if (an_q.size() > 0 && an_q[0].due <= cyc) begin
          e = an_q.pop_front();
          chk("an_rvalid_missing", 0, 1);
        end
        if (dbg_rvalid) begin
          if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", 1, 0);
          else begin
            e = dbg_q.pop_front();
            chk("dbg_rdata", dbg_rdata, e.data);
            chk("dbg_latency", cyc, e.due);
          end
        end else if (dbg_q.size() > 0 && dbg_q[0].due <= cyc) begin
          e = dbg_q.pop_front();
          chk("dbg_rvalid_missing", 0, 1);
        end
      end
    end
  end

  initial begin
    int first_dbg, n_dbg, guard;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 2048; a++) mem[b][a] = DW'($urandom);
    mem[0][5] = 12'hABC;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;

    // First round into bank 0, then one analyzer read of address 5.
    step(1, 0, 0, 0, '0, 0, '0);
    idle(1);
    step(0, 0, 0, 1, 11'h005, 0, '0);
    idle(4);

    // Analyzer and dumper both held: dumper wins exactly once, on the 64th cycle.
    first_dbg = -1; n_dbg = 0;
    for (int i = 0; i < 70; i++) begin
      step(0, 0, 0, 1, AW'($urandom), 1, AW'($urandom));
      if (last_dbg_gnt) begin
        n_dbg++;
        if (first_dbg < 0) first_dbg = i;
      end
    end
    chk("dbg_first_grant_idx", first_dbg, DBG_MAX_WAIT - 1);
    chk("dbg_grant_count", n_dbg, 1);
    idle(4);

    // Hung analyzer: timeout after TIMEOUT busy cycles; next round clears the flag.
    step(1, 1, 0, 0, '0, 0, '0);
    idle(TIMEOUT + 3);
    chk("to_f0_done", f0_done, 1);
    chk("to_timeout_err", timeout_err, 1);
    step(1, 0, 0, 0, '0, 0, '0);
    idle(1);
    chk("to_err_cleared", timeout_err, 0);

    // an_done on the very cycle the timeout would fire counts as a normal finish.
    guard = 0;
    while (!(m_active && !m_startp && m_busy == TIMEOUT - 1) && guard < 3 * TIMEOUT) begin
      idle(1);
      guard++;
    end
    chk("sametime_reached", guard < 3 * TIMEOUT, 1);
    step(0, 0, 1, 0, '0, 0, '0);
    idle(1);
    chk("sametime_f0_done", f0_done, 1);
    chk("sametime_timeout_err", timeout_err, 0);

    // Dumper read granted just before a swap returns the old bank's data.
    step(0, 0, 0, 0, '0, 1, 11'h007);
    step(1, 1, 0, 0, '0, 0, '0);
    idle(5);

    // Randomized traffic, including swaps mid-round and stray an_done pulses.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 79) == 0, 1'($urandom), $urandom_range(0, 24) == 0,
           1'($urandom), AW'($urandom), $urandom_range(0, 2) == 0, AW'($urandom));
    end
    idle(5);

    // Asynchronous reset in the middle of BUSY with reads in flight.
    step(1, 0, 0, 0, '0, 0, '0);
    idle(1);
    step(0, 0, 0, 1, AW'($urandom), 0, '0);
    step(0, 0, 0, 1, AW'($urandom), 1, AW'($urandom));
    @(posedge clk);
    #2;
    rst = 1'b0;
    start_round = 0; an_done = 0; an_req = 0; dbg_req = 0;
    model_reset();
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(6);
    chk("drain_an_q", an_q.size(), 0);
    chk("drain_dbg_q", dbg_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
